// File: rtl/icache_refill_axi.sv
// Instruction-cache line refill engine: one INCR read burst per miss on AXI3/AXI4,
// beats gathered into a line buffer and handed back as a single-cycle refill pulse.
module icache_refill_axi #(
   parameter int unsigned LINE_BEATS = 4,
   parameter logic [3:0]  ID         = 4'h0
) (
   input  logic                       aclk,
   input  logic                       aresetn,

   input  logic                       miss_req_valid,
   input  logic [31:0]                miss_req_addr,
   output logic                       miss_req_ready,

   input  logic                       refill_cancel,
   output logic                       refill_valid,
   output logic [31:0]                refill_addr,
   output logic [64*LINE_BEATS-1:0]   refill_data,
   output logic                       refill_err,

   output logic [31:0]                m_araddr,
   output logic [1:0]                 m_arburst,
   output logic [3:0]                 m_arcache,
   output logic [3:0]                 m_arid,
   output logic [7:0]                 m_arlen,
   output logic                       m_arlock,
   output logic [2:0]                 m_arprot,
   output logic [2:0]                 m_arsize,
   output logic                       m_arvalid,
   input  logic                       m_arready,

   input  logic [63:0]                m_rdata,
   input  logic [3:0]                 m_rid,
   input  logic                       m_rlast,
   input  logic [1:0]                 m_rresp,
   input  logic                       m_rvalid,
   output logic                       m_rready
);

   localparam int unsigned IDXW = $clog2(LINE_BEATS);
   localparam int unsigned CNTW = IDXW + 1;
   localparam int unsigned OFFW = $clog2(LINE_BEATS * 8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   logic [CNTW-1:0] beat_cnt;
   logic            err_q;
   logic            cancel_q;
   logic [31:0]     line_addr;

   logic            beat_c;
   logic            last_slot_c;
   logic            burst_end_c;
   logic            err_next_c;
   logic            cancel_next_c;
   logic            unused_inputs;

   // Constant read-address attributes: full-width INCR line burst, instruction access.
   assign m_arburst = 2'b01;
   assign m_arsize  = 3'b011;
   assign m_arlen   = 8'(LINE_BEATS - 1);
   assign m_arcache = 4'h0;
   assign m_arlock  = 1'b0;
   assign m_arprot  = 3'b100;
   assign m_arid    = ID;

   // The line-address register doubles as the AR address and the returned line address.
   assign m_araddr    = line_addr;
   assign refill_addr = line_addr;

   // Beat bookkeeping; only ever qualifies register updates, never an output.
   assign beat_c        = m_rready & m_rvalid;
   assign last_slot_c   = (beat_cnt == CNTW'(LINE_BEATS - 1));
   assign burst_end_c   = beat_c & (m_rlast | last_slot_c);
   assign err_next_c    = err_q | (m_rresp != 2'b00) | (m_rlast != last_slot_c);
   assign cancel_next_c = cancel_q | refill_cancel;

   // Read IDs are not checked and the in-line offset bits are discarded by design.
   assign unused_inputs = ^{m_rid, miss_req_addr[OFFW-1:0]};

   // Control FSM with registered handshake and refill outputs.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= S_IDLE;
         beat_cnt       <= '0;
         err_q          <= 1'b0;
         cancel_q       <= 1'b0;
         miss_req_ready <= 1'b1;
         m_arvalid      <= 1'b0;
         m_rready       <= 1'b0;
         refill_valid   <= 1'b0;
         refill_err     <= 1'b0;
      end else begin
         if (state != S_IDLE && refill_cancel) begin
            cancel_q <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (miss_req_valid) begin
                  beat_cnt       <= '0;
                  err_q          <= 1'b0;
                  cancel_q       <= 1'b0;
                  miss_req_ready <= 1'b0;
                  m_arvalid      <= 1'b1;
                  state          <= S_AR;
               end
            end
            S_AR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= S_R;
               end
            end
            S_R: begin
               if (beat_c) begin
                  beat_cnt <= beat_cnt + CNTW'(1);
                  err_q    <= err_next_c;
               end
               if (burst_end_c) begin
                  m_rready     <= 1'b0;
                  refill_valid <= ~cancel_next_c;
                  refill_err   <= err_next_c;
                  state        <= S_DONE;
               end
            end
            S_DONE: begin
               refill_valid   <= 1'b0;
               refill_err     <= 1'b0;
               miss_req_ready <= 1'b1;
               state          <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Line address and line buffer: loaded on request accept and per beat, never reset.
   always_ff @(posedge aclk) begin
      if (state == S_IDLE && miss_req_valid) begin
         line_addr <= {miss_req_addr[31:OFFW], OFFW'(0)};
      end
      if (beat_c) begin
         for (int unsigned i = 0; i < LINE_BEATS; i++) begin
            if (beat_cnt[IDXW-1:0] == IDXW'(i)) begin
               refill_data[64*i +: 64] <= m_rdata;
            end
         end
      end
   end

endmodule
